multicycle_controller: RTL and testbench
========================================

# multicycle_controller

FSM control unit for the multi-cycle RV32I core, replacing the single-cycle combinational decoder. It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. Memory accesses use a ready handshake with a timeout. The block resolves all six branch conditions, counts retired instructions, and halts in a trap state on fatal conditions.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- MAX_WAIT, 15, maximum consecutive memory wait cycles before a bus-timeout trap; 0 disables the timeout

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode (from IR)
- funct3  in  3  instruction funct3 (from IR)
- Zero, ALUR31, sltu  in  1 each  ALU flags: result==0, result[31], unsigned less-than
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request strobe
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath strobes and selects
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from op in every state
- halted  out  1  FSM is in TRAP
- trap_cause  out  2  00 none, 01 bus timeout, 10 illegal instruction
- instret  out  CNT_W  retired-instruction count

## Operation
- States and their next states:
  - FETCH → DECODE
  - DECODE → MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, JALR1, UPPER (lui/auipc)
  - MEMADR → MEMREAD or MEMWRITE
  - MEMREAD → MEMWB
  - EXECR/EXECI → ALUWB
  - JALR1 → JALR2 → ALUWB
  - JAL → ALUWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UPPER → FETCH
- Default output is 0/00 unless listed below.
  - FETCH: mem_req; A=00, B=10, ResultSrc=10; IRWrite = PCWrite = mem_ready.
  - DECODE: A=01, B=01 (branch/jal/auipc target into ALUOut).
  - MEMADR: A=10, B=01.
  - MEMREAD: mem_req, AdrSrc.
  - MEMWRITE: mem_req, AdrSrc, MemWrite = mem_ready.
  - MEMWB: ResultSrc=01, RegWrite.
  - EXECR: A=10, B=00, ALUOp=10.
  - EXECI: A=10, B=01, ALUOp=10.
  - ALUWB: RegWrite.
  - BRANCH: A=10, B=00, ALUOp=01; PCWrite = taken.
  - JAL: A=01, B=10, PCWrite.
  - JALR1: A=10, B=01.
  - JALR2: A=01, B=10, PCWrite.
  - UPPER: RegWrite; ResultSrc = op[5] ? 11 : 00.
- Branch taken by funct3:
  - 000 Zero
  - 001 !Zero
  - 100 ALUR31
  - 101 !ALUR31
  - 110 sltu
  - 111 !sltu
- Clearing the jalr target LSB is the datapath's job.
- FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
- Wait counter: counts consecutive cycles with mem_req=1 and mem_ready=0, and clears on every state change. If it reaches MAX_WAIT with mem_ready still 0, the FSM enters TRAP with cause 01.
- TRAP: all strobes 0, halted=1, trap_cause held. TRAP is exited only by reset.
- instret increments once per instruction, on the transition back to FETCH. It wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-decoded from the state register, except for these same-cycle combinational terms: mem_ready-gated strobes, branch-taken, ImmSrc, and ResultSrc in UPPER.
- Cycle counts with zero wait states (mem_ready=1 throughout):
  - branch, lui/auipc: 3
  - R-type, I-type, sw, jal: 4
  - lw, jalr: 5
- Each memory wait cycle adds 1 cycle.
- Reset:
  - While rst_n=0: state=FETCH, counters=0, halted=0, trap_cause=00; mem_req, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0, and other outputs carry FETCH encodings.
  - After rst_n deasserts, FETCH begins on the first rising edge.
  - Reset mid-instruction aborts it with no retire.
- If mem_ready=1 in the same cycle the counter equals MAX_WAIT, the access completes and no trap occurs.
- A counter wrap with a simultaneous retire gives instret=0.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - An unsupported opcode in DECODE causes TRAP with cause 10.
  - A branch with funct3 010 or 011 also causes TRAP with cause 10.
  - No instret increment for the trapping instruction.
- MC_ILLEGAL_TRAP_EN undefined:
  - An unsupported opcode makes DECODE → FETCH with no writes, and the instruction counts as retired.
  - Illegal branch funct3 values are not-taken.

## Test plan
- Reset, then add (0110011) with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in the 4th cycle; instret=1.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMWB reached 3 cycles late; RegWrite with ResultSrc=01; no trap.
- beq with Zero=1 gives PCWrite=1 in BRANCH. bltu with sltu=0 gives PCWrite=0. Both take 3 cycles.
- MAX_WAIT=4, mem_ready held 0 in FETCH → after 4 wait cycles halted=1, trap_cause=01, and all strobes stay 0 until rst_n is pulsed.
- op=0000000 → trap_cause=10 with MC_ILLEGAL_TRAP_EN defined. With it undefined: DECODE→FETCH, no writes, instret +1.
- CNT_W=4, run 16 addi instructions → instret wraps to 0. Assert rst_n low mid-sw → MemWrite never asserts, state=FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller                                        |
// | Description : Multi-cycle RV32I control FSM. Sequences fetch, decode,      |
// |               execute, memory and writeback over a shared ALU and memory   |
// |               port. Handles memory wait states with a timeout, resolves    |
// |               branch conditions, counts retired instructions and traps on  |
// |               fatal conditions.                                            |
// | Options     : define MC_ILLEGAL_TRAP_EN to trap on unsupported opcodes and |
// |               reserved branch funct3 encodings.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_controller #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             Zero_i,
  input  logic             ALUR31_i,
  input  logic             sltu_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             PCWrite_o,
  output logic             AdrSrc_o,
  output logic             IRWrite_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       ResultSrc_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [2:0]       ImmSrc_o,
  output logic             halted_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  // Opcodes understood by the controller
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  // FSM state encoding
  localparam logic [3:0] c_S_FETCH    = 4'd0;
  localparam logic [3:0] c_S_DECODE   = 4'd1;
  localparam logic [3:0] c_S_MEMADR   = 4'd2;
  localparam logic [3:0] c_S_MEMREAD  = 4'd3;
  localparam logic [3:0] c_S_MEMWRITE = 4'd4;
  localparam logic [3:0] c_S_MEMWB    = 4'd5;
  localparam logic [3:0] c_S_EXECR    = 4'd6;
  localparam logic [3:0] c_S_EXECI    = 4'd7;
  localparam logic [3:0] c_S_ALUWB    = 4'd8;
  localparam logic [3:0] c_S_BRANCH   = 4'd9;
  localparam logic [3:0] c_S_JAL      = 4'd10;
  localparam logic [3:0] c_S_JALR1    = 4'd11;
  localparam logic [3:0] c_S_JALR2    = 4'd12;
  localparam logic [3:0] c_S_UPPER    = 4'd13;
  localparam logic [3:0] c_S_TRAP     = 4'd14;

  localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
  localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b10;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic c_ILLEGAL_TRAP = 1'b1;
`else
  localparam logic c_ILLEGAL_TRAP = 1'b0;
`endif

  // Wait counter only needs to reach MAX_WAIT; MAX_WAIT = 0 disables it
  localparam int                  c_WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic                c_TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX   = c_WAIT_W'(MAX_WAIT);

  logic [3:0]          state_q, state_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    instret_q, instret_d;

  logic taken;
  logic timeout;
  logic retire;
  logic branch_f3_bad;
  logic mem_req_s, pcw_s, irw_s, memw_s, regw_s;

  // Branch condition resolved from funct3 and the ALU flags of the compare
  always_comb begin
    taken = 1'b0;
    case (funct3_i)
      3'b000:  taken = Zero_i;
      3'b001:  taken = ~Zero_i;
      3'b100:  taken = ALUR31_i;
      3'b101:  taken = ~ALUR31_i;
      3'b110:  taken = sltu_i;
      3'b111:  taken = ~sltu_i;
      default: taken = 1'b0;
    endcase
  end

  // Timeout fires only when the limit is already reached and the memory is still stalling
  always_comb begin
    branch_f3_bad = (funct3_i == 3'b010) || (funct3_i == 3'b011);
    timeout       = c_TIMEOUT_EN && mem_req_s && !mem_ready_i && (wait_q == c_WAIT_MAX);
  end

  // Next-state logic, including trap entry and cause capture
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      c_S_FETCH: begin
        if (mem_ready_i) begin
          state_d = c_S_DECODE;
        end else if (timeout) begin
          state_d = c_S_TRAP;
          cause_d = c_CAUSE_TIMEOUT;
        end
      end
      c_S_DECODE: begin
        case (op_i)
          c_OP_LOAD, c_OP_STORE: state_d = c_S_MEMADR;
          c_OP_RTYPE:            state_d = c_S_EXECR;
          c_OP_ITYPE:            state_d = c_S_EXECI;
          c_OP_JAL:              state_d = c_S_JAL;
          c_OP_JALR:             state_d = c_S_JALR1;
          c_OP_LUI, c_OP_AUIPC:  state_d = c_S_UPPER;
          c_OP_BRANCH: begin
            if (c_ILLEGAL_TRAP && branch_f3_bad) begin
              state_d = c_S_TRAP;
              cause_d = c_CAUSE_ILLEGAL;
            end else begin
              state_d = c_S_BRANCH;
            end
          end
          default: begin
            // Unsupported opcode: trap, or retire it as a no-op
            if (c_ILLEGAL_TRAP) begin
              state_d = c_S_TRAP;
              cause_d = c_CAUSE_ILLEGAL;
            end else begin
              state_d = c_S_FETCH;
            end
          end
        endcase
      end
      c_S_MEMADR:   state_d = op_i[5] ? c_S_MEMWRITE : c_S_MEMREAD;
      c_S_MEMREAD: begin
        if (mem_ready_i) begin
          state_d = c_S_MEMWB;
        end else if (timeout) begin
          state_d = c_S_TRAP;
          cause_d = c_CAUSE_TIMEOUT;
        end
      end
      c_S_MEMWRITE: begin
        if (mem_ready_i) begin
          state_d = c_S_FETCH;
        end else if (timeout) begin
          state_d = c_S_TRAP;
          cause_d = c_CAUSE_TIMEOUT;
        end
      end
      c_S_EXECR, c_S_EXECI, c_S_JAL, c_S_JALR2: state_d = c_S_ALUWB;
      c_S_JALR1:                                state_d = c_S_JALR2;
      c_S_MEMWB, c_S_ALUWB, c_S_BRANCH, c_S_UPPER: state_d = c_S_FETCH;
      c_S_TRAP:                                 state_d = c_S_TRAP;
      default:                                  state_d = c_S_FETCH;
    endcase
  end

  // Wait counter and retire counter next values
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (c_TIMEOUT_EN && mem_req_s && !mem_ready_i && (wait_q != c_WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
    retire    = (state_q != c_S_FETCH) && (state_d == c_S_FETCH);
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + 1'b1;
    end
  end

  // State, wait counter, trap cause and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_S_FETCH;
      wait_q    <= '0;
      cause_q   <= c_CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode plus the few same-cycle terms (ready gating, taken, UPPER result select)
  always_comb begin
    mem_req_s   = 1'b0;
    pcw_s       = 1'b0;
    AdrSrc_o    = 1'b0;
    irw_s       = 1'b0;
    memw_s      = 1'b0;
    regw_s      = 1'b0;
    ResultSrc_o = 2'b00;
    ALUSrcA_o   = 2'b00;
    ALUSrcB_o   = 2'b00;
    ALUOp_o     = 2'b00;
    case (state_q)
      c_S_FETCH: begin
        mem_req_s   = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        irw_s       = mem_ready_i;
        pcw_s       = mem_ready_i;
      end
      c_S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
      end
      c_S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
      end
      c_S_MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc_o  = 1'b1;
      end
      c_S_MEMWRITE: begin
        mem_req_s = 1'b1;
        AdrSrc_o  = 1'b1;
        memw_s    = mem_ready_i;
      end
      c_S_MEMWB: begin
        ResultSrc_o = 2'b01;
        regw_s      = 1'b1;
      end
      c_S_EXECR: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b10;
      end
      c_S_EXECI: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b10;
      end
      c_S_ALUWB: regw_s = 1'b1;
      c_S_BRANCH: begin
        ALUSrcA_o = 2'b10;
        ALUOp_o   = 2'b01;
        pcw_s     = taken;
      end
      c_S_JAL, c_S_JALR2: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        pcw_s     = 1'b1;
      end
      c_S_JALR1: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
      end
      c_S_UPPER: begin
        regw_s      = 1'b1;
        ResultSrc_o = op_i[5] ? 2'b11 : 2'b00;
      end
      default: begin
        // TRAP: everything stays at its inactive value
      end
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op_i)
      c_OP_STORE:           ImmSrc_o = 3'b001;
      c_OP_BRANCH:          ImmSrc_o = 3'b010;
      c_OP_JAL:             ImmSrc_o = 3'b011;
      c_OP_LUI, c_OP_AUIPC: ImmSrc_o = 3'b100;
      default:              ImmSrc_o = 3'b000;
    endcase
  end

  // Strobes are held inactive while reset is asserted
  always_comb begin
    mem_req_o    = mem_req_s & rst_n;
    PCWrite_o    = pcw_s & rst_n;
    IRWrite_o    = irw_s & rst_n;
    MemWrite_o   = memw_s & rst_n;
    RegWrite_o   = regw_s & rst_n;
    halted_o     = (state_q == c_S_TRAP);
    trap_cause_o = cause_q;
    instret_o    = instret_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Testbench for multicycle_controller: directed vector table, randomized
// instruction stream against an instruction-level model, and corner cases.
module tb_multicycle_controller;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       op_i;
  logic [2:0]       funct3_i;
  logic             Zero_i, ALUR31_i, sltu_i, mem_ready_i;
  logic             mem_req_o, PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o;
  logic [1:0]       ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, trap_cause_o;
  logic [2:0]       ImmSrc_o;
  logic             halted_o;
  logic [CNT_W-1:0] instret_o;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct3_i(funct3_i),
    .Zero_i(Zero_i), .ALUR31_i(ALUR31_i), .sltu_i(sltu_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .PCWrite_o(PCWrite_o), .AdrSrc_o(AdrSrc_o),
    .IRWrite_o(IRWrite_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .ResultSrc_o(ResultSrc_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o), .ImmSrc_o(ImmSrc_o), .halted_o(halted_o),
    .trap_cause_o(trap_cause_o), .instret_o(instret_o)
  );

  // {mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, halted, trap_cause}
  logic [19:0] out_vec;
  assign out_vec = {mem_req_o, PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o,
                    ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ImmSrc_o, halted_o, trap_cause_o};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [2:0]  flags;   // {Zero, ALUR31, sltu}
    logic        ready;
    logic [19:0] exp;
    logic [3:0]  ir;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] E(input logic [5:0] s, input logic [1:0] rs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] ao, input logic [2:0] im);
    return {s, rs, a, b, ao, im, 3'b000};
  endfunction

  function automatic vec_t row(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] fl,
                               input logic rdy, input logic [19:0] ex, input logic [3:0] ir);
    vec_t v;
    v.op = op; v.f3 = f3; v.flags = fl; v.ready = rdy; v.exp = ex; v.ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int ncyc);
    op_i = op; funct3_i = 3'b000; mem_ready_i = 1'b1;
    for (int c = 0; c < ncyc; c++) tick();
  endtask

  // Instruction-level reference: spec-level rules for one instruction
  function automatic int base_cycles(input logic [6:0] op);
    case (op)
      OP_B, OP_LUI, OP_AUI:        return 3;
      OP_R, OP_I, OP_SW, OP_JAL:   return 4;
      OP_LW, OP_JR:                return 5;
      default:                     return 2;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [2:0] fl);
    case (f3)
      3'd0: return fl[2];
      3'd1: return !fl[2];
      3'd4: return fl[1];
      3'd5: return !fl[1];
      3'd6: return fl[0];
      3'd7: return !fl[0];
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[$];
    logic [6:0] rop;
    logic [2:0] rf3, rfl;
    logic [3:0] prev, exp_cnt;
    int cyc, waits, run, nreg, nmw, npc, nir, nreq, nhalt;
    int e_reg, e_mw, e_pc, e_req;
    bit done;

    // ---------------- reset state ----------------
    rst_n = 1'b0; op_i = OP_R; funct3_i = 3'b000;
    Zero_i = 1'b0; ALUR31_i = 1'b0; sltu_i = 1'b0; mem_ready_i = 1'b1;
    tick();
    #2;
    check("reset_outputs", out_vec, E(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check("reset_instret", instret_o, 0);
    tick();
    rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    // add
    tbl.push_back(row(OP_R, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 0));
    tbl.push_back(row(OP_R, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000), 0));
    tbl.push_back(row(OP_R, 0, 0, 1, E(6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000), 0));
    tbl.push_back(row(OP_R, 0, 0, 1, E(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 0));
    // lw with 3 wait cycles in MEMREAD
    tbl.push_back(row(OP_LW, 2, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 1, E(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 0, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 0, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 0, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 1, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 1));
    tbl.push_back(row(OP_LW, 2, 0, 1, E(6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000), 1));
    // beq, Zero=1: taken
    tbl.push_back(row(OP_B, 0, 3'b100, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010), 2));
    tbl.push_back(row(OP_B, 0, 3'b100, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010), 2));
    tbl.push_back(row(OP_B, 0, 3'b100, 1, E(6'b010000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010), 2));
    // bltu, sltu=0: not taken
    tbl.push_back(row(OP_B, 6, 3'b110, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010), 3));
    tbl.push_back(row(OP_B, 6, 3'b110, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010), 3));
    tbl.push_back(row(OP_B, 6, 3'b110, 1, E(6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010), 3));
    // sw with one wait in MEMWRITE
    tbl.push_back(row(OP_SW, 2, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001), 4));
    tbl.push_back(row(OP_SW, 2, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b001), 4));
    tbl.push_back(row(OP_SW, 2, 0, 1, E(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001), 4));
    tbl.push_back(row(OP_SW, 2, 0, 0, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001), 4));
    tbl.push_back(row(OP_SW, 2, 0, 1, E(6'b101010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001), 4));
    // jal
    tbl.push_back(row(OP_JAL, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b011), 5));
    tbl.push_back(row(OP_JAL, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b011), 5));
    tbl.push_back(row(OP_JAL, 0, 0, 1, E(6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011), 5));
    tbl.push_back(row(OP_JAL, 0, 0, 1, E(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011), 5));
    // jalr
    tbl.push_back(row(OP_JR, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 6));
    tbl.push_back(row(OP_JR, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000), 6));
    tbl.push_back(row(OP_JR, 0, 0, 1, E(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000), 6));
    tbl.push_back(row(OP_JR, 0, 0, 1, E(6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000), 6));
    tbl.push_back(row(OP_JR, 0, 0, 1, E(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 6));
    // lui then auipc
    tbl.push_back(row(OP_LUI, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b100), 7));
    tbl.push_back(row(OP_LUI, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100), 7));
    tbl.push_back(row(OP_LUI, 0, 0, 1, E(6'b000001, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100), 7));
    tbl.push_back(row(OP_AUI, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b100), 8));
    tbl.push_back(row(OP_AUI, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100), 8));
    tbl.push_back(row(OP_AUI, 0, 0, 1, E(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100), 8));
    // addi with one wait in FETCH
    tbl.push_back(row(OP_I, 0, 0, 0, E(6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 9));
    tbl.push_back(row(OP_I, 0, 0, 1, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 9));
    tbl.push_back(row(OP_I, 0, 0, 1, E(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000), 9));
    tbl.push_back(row(OP_I, 0, 0, 1, E(6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000), 9));
    tbl.push_back(row(OP_I, 0, 0, 1, E(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), 9));
    tbl.push_back(row(OP_R, 0, 0, 0, E(6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000), 10));

    for (int i = 0; i < tbl.size(); i++) begin
      op_i = tbl[i].op; funct3_i = tbl[i].f3;
      {Zero_i, ALUR31_i, sltu_i} = tbl[i].flags;
      mem_ready_i = tbl[i].ready;
      #2;
      check($sformatf("vec%0d_outputs", i), out_vec, tbl[i].exp);
      check($sformatf("vec%0d_instret", i), instret_o, tbl[i].ir);
      tick();
    end

    // ---------------- randomized instruction stream ----------------
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JR, OP_LUI, OP_AUI};
`ifndef MC_ILLEGAL_TRAP_EN
    ops.push_back(OP_BAD);
`endif
    do_reset();
    exp_cnt = 4'd0;
    for (int k = 0; k < 60; k++) begin
      rop = ops[$urandom_range(0, ops.size() - 1)];
      rf3 = 3'($urandom_range(0, 7));
`ifdef MC_ILLEGAL_TRAP_EN
      if (rop == OP_B && (rf3 == 3'd2 || rf3 == 3'd3)) rf3 = 3'd0;
`endif
      rfl = 3'($urandom_range(0, 7));
      op_i = rop; funct3_i = rf3; {Zero_i, ALUR31_i, sltu_i} = rfl;
      prev = instret_o;
      cyc = 0; waits = 0; run = 0; nreg = 0; nmw = 0; npc = 0; nir = 0; nreq = 0; nhalt = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
        if (mem_req_o && run < 3 && $urandom_range(0, 3) == 0) begin
          mem_ready_i = 1'b0; run++; waits++;
        end else begin
          mem_ready_i = 1'b1; run = 0;
        end
        #2;
        nreg += int'(RegWrite_o); nmw += int'(MemWrite_o); npc += int'(PCWrite_o);
        nir  += int'(IRWrite_o);  nreq += int'(mem_req_o); nhalt += int'(halted_o);
        cyc++;
        tick();
        if (instret_o !== prev) done = 1'b1;
      end
      e_reg = (rop == OP_SW || rop == OP_B || rop == OP_BAD) ? 0 : 1;
      e_mw  = (rop == OP_SW) ? 1 : 0;
      e_pc  = 1 + ((rop == OP_JAL || rop == OP_JR) ? 1 : 0) + ((rop == OP_B) ? int'(br_taken(rf3, rfl)) : 0);
      e_req = 1 + ((rop == OP_LW || rop == OP_SW) ? 1 : 0) + waits;
      exp_cnt = exp_cnt + 4'd1;
      check($sformatf("rnd%0d_op%b_cycles", k, rop), cyc, base_cycles(rop) + waits);
      check($sformatf("rnd%0d_regwrite", k), nreg, e_reg);
      check($sformatf("rnd%0d_memwrite", k), nmw, e_mw);
      check($sformatf("rnd%0d_pcwrite", k), npc, e_pc);
      check($sformatf("rnd%0d_irwrite", k), nir, 1);
      check($sformatf("rnd%0d_memreq", k), nreq, e_req);
      check($sformatf("rnd%0d_halted", k), nhalt, 0);
      check($sformatf("rnd%0d_instret", k), instret_o, exp_cnt);
    end

    // ---------------- ready arrives exactly at the wait limit ----------------
    do_reset();
    op_i = OP_R; funct3_i = 3'b000;
    mem_ready_i = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) tick();
    mem_ready_i = 1'b1;
    #2;
    check("boundary_fetch_outputs", out_vec, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    tick();
    run_instr(OP_R, 3);
    check("boundary_instret", instret_o, 1);
    check("boundary_halted", halted_o, 0);

    // ---------------- bus timeout in FETCH ----------------
    do_reset();
    op_i = OP_R;
    mem_ready_i = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) tick();
    #2;
    check("timeout_last_wait_halted", halted_o, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      mem_ready_i = (c != 0);
      #2;
      check($sformatf("timeout_trap%0d_outputs", c), out_vec, 20'b000000_00_00_00_00_000_1_01);
      tick();
    end
    do_reset();
    #2;
    check("timeout_cleared_by_reset", {halted_o, trap_cause_o}, 3'b000);
    tick();

    // ---------------- unsupported opcode ----------------
    do_reset();
    run_instr(OP_BAD, 1);
    #2;
    check("illegal_decode_strobes", out_vec[19:14], 6'b000000);
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    check("illegal_trap_state", {halted_o, trap_cause_o}, 3'b110);
    check("illegal_instret", instret_o, 0);
`else
    check("illegal_back_to_fetch", mem_req_o, 1);
    check("illegal_instret", instret_o, 1);
`endif

    // ---------------- instret wrap ----------------
    do_reset();
    for (int n = 0; n < 15; n++) run_instr(OP_I, 4);
    check("wrap_instret_15", instret_o, 15);
    run_instr(OP_I, 4);
    check("wrap_instret_0", instret_o, 0);

    // ---------------- reset in the middle of a store ----------------
    do_reset();
    run_instr(OP_SW, 3);
    mem_ready_i = 1'b0;
    #2;
    check("midsw_wait_outputs", out_vec, E(6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
    tick();
    rst_n = 1'b0;
    mem_ready_i = 1'b1;
    #2;
    check("midsw_reset_outputs", out_vec, E(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001));
    tick();
    check("midsw_instret", instret_o, 0);
    rst_n = 1'b1;
    #2;
    check("midsw_fetch_outputs", out_vec, E(6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
